// File: rtl/prog_pkg.sv
`default_nettype none
// ============================================================================
// prog_pkg
//   Shared state encoding and default constants for the program host.
//   Revision: 1.0
// ============================================================================
package prog_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RESET = 3'd1,
        RUN   = 3'd2,
        READ  = 3'd3,
        SEND  = 3'd4,
        DONE  = 3'd5
    } host_state_e;

    localparam int unsigned c_RST_CYCLES = 4;
    localparam int unsigned c_TIMEOUT    = 1 << 20;
    localparam int unsigned c_CNT_W      = 24;
    localparam int unsigned c_AW         = 8;
    localparam int unsigned c_DW         = 8;
    localparam int unsigned c_RD_BASE    = 0;
    localparam int unsigned c_RD_LEN     = 8;

endpackage : prog_pkg
`default_nettype wire

// File: rtl/prog_host.sv
`default_nettype none
// ============================================================================
// prog_host
//   Runs the core through reset/ack, then streams RD_LEN result bytes out.
//   Revision: 1.0
// ============================================================================
module prog_host
    import prog_pkg::*;
#(
    parameter int unsigned RST_CYCLES = c_RST_CYCLES,
    parameter int unsigned TIMEOUT    = c_TIMEOUT,
    parameter int unsigned CNT_W      = c_CNT_W,
    parameter int unsigned AW         = c_AW,
    parameter int unsigned DW         = c_DW,
    parameter int unsigned RD_BASE    = c_RD_BASE,
    parameter int unsigned RD_LEN     = c_RD_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             timed_out,
    output logic             dut_reset,
    input  logic             dut_ack,
    output logic [CNT_W-1:0] cycle_count,
    output logic             mem_rd_en,
    output logic [AW-1:0]    mem_rd_addr,
    input  logic [DW-1:0]    mem_rd_data,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [DW-1:0]    res_data,
    output logic [AW-1:0]    res_addr,
    output logic             res_last
);

    localparam int unsigned   c_RCW       = $clog2(RST_CYCLES) + 1;
    localparam logic [c_RCW-1:0] c_RST_LAST = c_RCW'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [AW-1:0]    c_BASE     = AW'(RD_BASE);
    localparam logic [AW-1:0]    c_LAST_IDX = AW'(RD_LEN - 1);

    host_state_e      r_state;
    logic [c_RCW-1:0] r_rst_cnt;
    logic [AW-1:0]    r_idx;
    logic [CNT_W-1:0] r_cycle_count;
    logic             r_timed_out;
    logic             r_dut_reset;
    logic             r_busy;
    logic             r_done;
    logic             r_mem_rd_en;
    logic [AW-1:0]    r_mem_rd_addr;
    logic             r_res_valid;
    logic [DW-1:0]    r_res_data;
    logic [AW-1:0]    r_res_addr;
    logic             r_res_last;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_rst_cnt     <= '0;
            r_idx         <= '0;
            r_cycle_count <= '0;
            r_timed_out   <= 1'b0;
            r_dut_reset   <= 1'b1;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_res_valid   <= 1'b0;
            r_res_data    <= '0;
            r_res_addr    <= '0;
            r_res_last    <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (start) begin
                        r_state       <= RESET;
                        r_rst_cnt     <= '0;
                        r_idx         <= '0;
                        r_cycle_count <= '0;
                        r_timed_out   <= 1'b0;
                        r_dut_reset   <= 1'b1;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                    end
                end
                RESET: begin
                    if (r_rst_cnt == c_RST_LAST) begin
                        r_state     <= RUN;
                        r_dut_reset <= 1'b0;
                    end else begin
                        r_rst_cnt <= r_rst_cnt + 1'b1;
                    end
                end
                RUN: begin
                    // A zero count marks the first RUN cycle, where ack may be stale.
                    if (dut_ack && (r_cycle_count != '0)) begin
                        r_state       <= READ;
                        r_mem_rd_en   <= 1'b1;
                        r_mem_rd_addr <= c_BASE + r_idx;
                    end else begin
                        if (r_cycle_count != '1) begin
                            r_cycle_count <= r_cycle_count + 1'b1;
                        end
                        if (r_cycle_count == c_TO_LAST) begin
                            r_state     <= DONE;
                            r_timed_out <= 1'b1;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                READ: begin
                    r_state       <= SEND;
                    r_res_data    <= mem_rd_data;
                    r_res_addr    <= r_mem_rd_addr;
                    r_res_last    <= (r_idx == c_LAST_IDX);
                    r_res_valid   <= 1'b1;
                    r_mem_rd_en   <= 1'b0;
                    r_mem_rd_addr <= '0;
                end
                SEND: begin
                    if (res_ready) begin
                        r_res_valid <= 1'b0;
                        if (r_res_last) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= READ;
                            r_idx         <= r_idx + 1'b1;
                            r_mem_rd_en   <= 1'b1;
                            r_mem_rd_addr <= c_BASE + r_idx + AW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign timed_out   = r_timed_out;
    assign dut_reset   = r_dut_reset;
    assign cycle_count = r_cycle_count;
    assign mem_rd_en   = r_mem_rd_en;
    assign mem_rd_addr = r_mem_rd_addr;
    assign res_valid   = r_res_valid;
    assign res_data    = r_res_data;
    assign res_addr    = r_res_addr;
    assign res_last    = r_res_last;

endmodule : prog_host
`default_nettype wire
